// File: rtl/regfile_2r1w.sv
// Register bank with one synchronous write port and two registered read ports, with write-first forwarding.
// Optional REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_2r1w #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b
);

  // One extra bit so NUM_REGS = 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_ok_s;
  logic              rd_in_range_a_s;
  logic              rd_in_range_b_s;
  logic [DATA_W-1:0] rd_next_a_s;
  logic [DATA_W-1:0] rd_next_b_s;

  assign rd_in_range_a_s = ({1'b0, rd_addr_a} < NUM_REGS_L);
  assign rd_in_range_b_s = ({1'b0, rd_addr_b} < NUM_REGS_L);

  // Write qualification: in-range address, and register 0 protected when hardwired.
  always_comb begin
    wr_ok_s = 1'b0;
`ifdef REGFILE_R0_ZERO_EN
    if (wr_en && ({1'b0, wr_addr} < NUM_REGS_L) && (wr_addr != {ADDR_W{1'b0}})) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
`else
    if (wr_en && ({1'b0, wr_addr} < NUM_REGS_L)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
`endif
  end

  // Next read data per port; a blocked write to r0 never forwards since wr_ok_s excludes it.
  always_comb begin
    rd_next_a_s = {DATA_W{1'b0}};
    rd_next_b_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, rd_addr_a} == (ADDR_W+1)'(i)) begin
        rd_next_a_s = regs_r[i];
      end else begin
        rd_next_a_s = rd_next_a_s;
      end
      if ({1'b0, rd_addr_b} == (ADDR_W+1)'(i)) begin
        rd_next_b_s = regs_r[i];
      end else begin
        rd_next_b_s = rd_next_b_s;
      end
    end
    if (!rd_in_range_a_s) begin
      rd_next_a_s = {DATA_W{1'b0}};
    end else if (wr_ok_s && (wr_addr == rd_addr_a)) begin
      rd_next_a_s = wr_data;
    end else begin
      rd_next_a_s = rd_next_a_s;
    end
    if (!rd_in_range_b_s) begin
      rd_next_b_s = {DATA_W{1'b0}};
    end else if (wr_ok_s && (wr_addr == rd_addr_b)) begin
      rd_next_b_s = wr_data;
    end else begin
      rd_next_b_s = rd_next_b_s;
    end
  end

  // Register bank storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok_s && ({1'b0, wr_addr} == (ADDR_W+1)'(i))) begin
          regs_r[i] <= wr_data;
        end
      end
    end
  end

  // Read port A: data holds when idle, valid follows the enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a  <= {DATA_W{1'b0}};
      rd_valid_a <= 1'b0;
    end else if (rd_en_a) begin
      rd_data_a  <= rd_next_a_s;
      rd_valid_a <= 1'b1;
    end else begin
      rd_valid_a <= 1'b0;
    end
  end

  // Read port B: identical behaviour to port A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_b  <= {DATA_W{1'b0}};
      rd_valid_b <= 1'b0;
    end else if (rd_en_b) begin
      rd_data_b  <= rd_next_b_s;
      rd_valid_b <= 1'b1;
    end else begin
      rd_valid_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised and directed bench for regfile_2r1w (NUM_REGS=12) against an array-based reference model.
// Expectations follow REGFILE_R0_ZERO_EN when it is defined.
module tb_regfile_2r1w;

  localparam int DW = 16;
  localparam int NR = 12;
  localparam int AW = 4;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic          rd_valid_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic          rd_valid_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          exp_va;
  logic          exp_vb;

  regfile_2r1w #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit r0_hardwired();
`ifdef REGFILE_R0_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Value a read of addr sees at an edge, given the write presented at that same edge.
  function automatic logic [DW-1:0] model_read(input int addr, input bit we, input int wa,
                                               input logic [DW-1:0] wd);
    if (addr >= NR) return 16'h0000;
    if (r0_hardwired() && addr == 0) return 16'h0000;
    if (we && wa == addr) return wd;
    return mdl[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mdl[i] = 16'h0000;
    exp_a = 16'h0000; exp_b = 16'h0000; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  task automatic cycle(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit ea, input int aa, input bit eb, input int ab);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_en_a = ea; rd_addr_a = AW'(aa);
    rd_en_b = eb; rd_addr_b = AW'(ab);
    if (ea) exp_a = model_read(aa, we, wa, wd);
    if (eb) exp_b = model_read(ab, we, wa, wd);
    exp_va = ea;
    exp_vb = eb;
    if (we && wa < NR && !(r0_hardwired() && wa == 0)) mdl[wa] = wd;
    @(posedge clk);
    #1;
    check_eq("rd_data_a", 32'(rd_data_a), 32'(exp_a));
    check_eq("rd_valid_a", 32'(rd_valid_a), 32'(exp_va));
    check_eq("rd_data_b", 32'(rd_data_b), 32'(exp_b));
    check_eq("rd_valid_b", 32'(rd_valid_b), 32'(exp_vb));
  endtask

  task automatic async_reset_pulse();
    reset_n = 1'b0;
    #2;
    check_eq("rst_data_a", 32'(rd_data_a), 32'h0);
    check_eq("rst_data_b", 32'(rd_data_b), 32'h0);
    check_eq("rst_valid_a", 32'(rd_valid_a), 32'h0);
    check_eq("rst_valid_b", 32'(rd_valid_b), 32'h0);
    model_clear();
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 16'h0000;
    rd_en_a = 1'b0; rd_addr_a = 4'h0; rd_en_b = 1'b0; rd_addr_b = 4'h0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("init_data_a", 32'(rd_data_a), 32'h0);
    check_eq("init_valid_b", 32'(rd_valid_b), 32'h0);
    reset_n = 1'b1;

    // Reset mid-operation
    cycle(1, 5, 16'hBEEF, 0, 0, 0, 0);
    cycle(0, 0, 16'h0000, 1, 5, 0, 0);
    check_eq("r5_beef", 32'(rd_data_a), 32'h0000BEEF);
    async_reset_pulse();
    cycle(0, 0, 16'h0000, 1, 5, 1, 5);
    check_eq("r5_after_rst", 32'(rd_data_a), 32'h0);

    // Basic write/read on both ports, then hold
    cycle(1, 3, 16'h1234, 0, 0, 0, 0);
    cycle(0, 0, 16'h0000, 1, 3, 1, 3);
    check_eq("basic_a", 32'(rd_data_a), 32'h00001234);
    check_eq("basic_b", 32'(rd_data_b), 32'h00001234);
    cycle(0, 0, 16'h0000, 0, 3, 0, 3);
    check_eq("hold_a", 32'(rd_data_a), 32'h00001234);

    // Forwarding
    cycle(1, 7, 16'h00AA, 0, 0, 0, 0);
    cycle(1, 7, 16'h5555, 1, 7, 0, 0);
    check_eq("fwd_a", 32'(rd_data_a), 32'h00005555);
    cycle(0, 0, 16'h0000, 0, 0, 1, 7);
    check_eq("fwd_b_next", 32'(rd_data_b), 32'h00005555);
    cycle(1, 9, 16'h7E57, 1, 9, 1, 9);
    check_eq("fwd_both_b", 32'(rd_data_b), 32'h00007E57);

    // Independent ports
    cycle(1, 1, 16'h0001, 0, 0, 0, 0);
    cycle(1, 2, 16'h0002, 0, 0, 0, 0);
    cycle(0, 0, 16'h0000, 1, 1, 1, 2);
    check_eq("indep_a", 32'(rd_data_a), 32'h00000001);
    check_eq("indep_b", 32'(rd_data_b), 32'h00000002);

    // Out of range write and read, no forwarding out of range
    cycle(1, 13, 16'hFFFF, 1, 13, 0, 0);
    check_eq("oor_read", 32'(rd_data_a), 32'h0);
    for (int i = 0; i < NR; i += 2) cycle(0, 0, 16'h0000, 1, i, 1, i + 1);
    cycle(0, 0, 16'h0000, 1, 15, 1, 12);

    // Register 0 write with same-edge read
    cycle(1, 0, 16'hABCD, 1, 0, 0, 0);
    check_eq("r0_fwd", 32'(rd_data_a), r0_hardwired() ? 32'h0 : 32'h0000ABCD);
    cycle(0, 0, 16'h0000, 0, 0, 1, 0);

    // Randomised traffic with one mid-run async reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) async_reset_pulse();
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 15), DW'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 15));
    end

    // Final sweep of every register through both ports
    for (int i = 0; i < NR; i++) cycle(0, 0, 16'h0000, 1, i, 1, NR - 1 - i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
